// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional early termination when the remaining multiplier digits are all zero: define BOOTH_MUL_EARLY_TERM_EN.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_src1,
  input  logic [WIDTH-1:0]   in_src2,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               busy
);
  localparam int XW = WIDTH + 2;
  localparam int N  = XW / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [XW:0]          mlt_q, mlt_d, mlt_sh;
  logic [2*XW-1:0]      mcd_q, mcd_d, acc_q, acc_d, pp, sum;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic [XW-1:0]        ext1;
  logic [2*XW-1:0]      ext2;
  logic                 one, two, neg, last;

  assign ext1   = {{2{in_signed & in_src1[WIDTH-1]}}, in_src1};
  assign ext2   = {{(WIDTH+4){in_signed & in_src2[WIDTH-1]}}, in_src2};
  assign one    = mlt_q[0] ^ mlt_q[1];
  assign two    = (mlt_q[2:0] == 3'b011) || (mlt_q[2:0] == 3'b100);
  assign neg    = mlt_q[2] & ~(mlt_q[1] & mlt_q[0]);
  assign pp     = one ? mcd_q : two ? {mcd_q[2*XW-2:0], 1'b0} : '0;
  // Negative digits: one's complement plus carry-in.
  assign sum    = acc_q + (neg ? ~pp : pp) + {{(2*XW-1){1'b0}}, neg};
  assign mlt_sh = {{2{mlt_q[XW]}}, mlt_q[XW:2]};
`ifdef BOOTH_MUL_EARLY_TERM_EN
  assign last   = (cnt_q == CW'(N-1)) || (&mlt_sh) || ~(|mlt_sh);
`else
  assign last   = cnt_q == CW'(N-1);
`endif

  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign out_result = res_q;

  always_comb begin
    state_d = state_q;
    mlt_d   = mlt_q;
    mcd_d   = mcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (state_q == IDLE && in_valid) begin
      state_d = CALC;
      mlt_d   = {ext1, 1'b0};
      mcd_d   = ext2;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      mlt_d   = mlt_sh;
      mcd_d   = {mcd_q[2*XW-3:0], 2'b00};
      acc_d   = sum;
      cnt_d   = cnt_q + CW'(1);
      state_d = last ? DONE : CALC;
      res_d   = last ? sum[2*WIDTH-1:0] : res_q;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      mlt_q   <= '0;
      mcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mlt_q   <= mlt_d;
      mcd_q   <= mcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: vector table, random ops, backpressure and mid-operation reset checks at WIDTH=32.
module tb_booth_mul_seq;
  logic        clk = 0;
  logic        resetn = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_src1 = 0;
  logic [31:0] in_src2 = 0;
  logic        in_signed = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [63:0] out_result;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [63:0] q[$];
  logic [63:0] held;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] e;
  } vec_t;
  vec_t tbl[10];

  booth_mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'b0, a};
    y = s ? {{32{b[31]}}, b} : {32'b0, b};
    return x * y;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [63:0] e);
    @(negedge clk);
    in_src1 = a; in_src2 = b; in_signed = s; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_src1 = $urandom; in_src2 = $urandom; in_signed = 1'($urandom);
    q.push_back(e);
    chk("busy_after_accept", {63'b0, busy}, 64'd1);
  endtask

  task automatic wait_result(input int exp_lat);
    int lat;
    logic [63:0] e;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    e = q.pop_front();
    held = e;
    chk("result", out_result, e);
  endtask

  task automatic finish_hs();
    @(posedge clk); #1;
    chk("in_ready_after_hs", {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    tbl[0] = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    tbl[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
    tbl[4] = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
    tbl[5] = '{32'd12345,    32'd678,      1'b0, 64'd8369910};
    tbl[6] = '{32'h00000000, 32'hDEADBEEF, 1'b0, 64'h0};
    tbl[7] = '{32'hFFFFFFFF, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFFB};
    tbl[8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};
    tbl[9] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    resetn = 1;

    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e);
      wait_result(17);
      finish_hs();
    end

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom; b = $urandom; s = 1'(i & 1);
      start_op(a, b, s, model(a, b, s));
      wait_result(17);
      finish_hs();
    end

    out_ready = 0;
    start_op(32'h12345678, 32'h9ABCDEF0, 1'b0, model(32'h12345678, 32'h9ABCDEF0, 1'b0));
    wait_result(17);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1; in_src1 = $urandom; in_src2 = $urandom;
      @(posedge clk); #1;
      chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_out_result", out_result, held);
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("hs_out_valid", {63'b0, out_valid}, 64'd0);
    chk("hs_no_overlap", {63'b0, in_ready}, 64'd1);
    chk("hs_busy", {63'b0, busy}, 64'd0);
    start_op(32'hFFFFFF9C, 32'd3, 1'b1, 64'hFFFFFFFFFFFFFED4);
    wait_result(17);
    finish_hs();

    start_op(32'hCAFEBABE, 32'h0BADF00D, 1'b0, 64'h0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    void'(q.pop_front());
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("mid_rst_out_result", out_result, 64'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("mid_rst_no_valid", 64'(seen), 64'd0);
    end
    start_op(32'd12345, 32'd678, 1'b0, 64'd8369910);
    wait_result(17);
    finish_hs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
